count_rate_controller: RTL and testbench
========================================

Name: count_rate_controller

Overview:
Sequencing controller for the 8-bit counter datapath. It replaces the derived divided clock with a single-clock prescaler that produces clock-enable ticks. It also owns the run/pause/clear state machine and the up/down count register. It sits between the debounced button inputs and the display/LED logic, and everything runs on the board clock.

Parameters:
DIV_VAL, 4999, base prescaler terminal value; base tick period is DIV_VAL+1 clk cycles.
WIDTH, 8, count register width.

Ports:
clk  input  1  board clock; all logic is on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle pulse; requests RUN.
stop  input  1  single-cycle pulse; requests PAUSE.
clear  input  1  level; forces IDLE and count 0.
dir  input  1  1 = count up, 0 = count down; sampled at each tick.
rate_sel  input  2  tick period P = (DIV_VAL+1) << rate_sel.
count  output  WIDTH  current count value.
running  output  1  high while the FSM is in RUN.
tick  output  1  one-cycle pulse, coincident with each new count value.
wrap  output  1  one-cycle pulse, coincident with a wrap-around count value.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: count=0, running=0, tick=0, wrap=0, prescaler=0, state=IDLE.
- States:
  - IDLE: count=0, prescaler held at 0.
  - RUN: prescaler increments every cycle.
  - PAUSE: count and prescaler both hold.
- Transitions, in priority order:
  1. clear (any state) -> IDLE; count<=0, prescaler<=0.
  2. stop in RUN -> PAUSE.
  3. start in IDLE or PAUSE -> RUN; prescaler<=0.
  - stop and start in the same cycle: stop wins, and start is ignored that cycle.
  - start in RUN and stop in IDLE/PAUSE are ignored.
- Prescaler:
  - Width is sufficient for (DIV_VAL+1)*8-1.
  - In RUN, when prescaler >= P-1: prescaler<=0, count<=count+1 (dir=1) or count-1 (dir=0), and tick<=1. Otherwise prescaler<=prescaler+1 and tick<=0.
  - The >= compare guarantees that lowering rate_sel mid-run produces a tick on the next edge rather than an overrun.
- Tick timing: the first tick after a start edge appears exactly P cycles later. A resume from PAUSE restarts a full period.
- Registered outputs: tick, wrap and the new count all appear in the same cycle, with zero combinational paths from inputs to outputs.
- Wrap-around:
  - Up from 2^WIDTH-1 -> 0 with wrap=1.
  - Down from 0 -> 2^WIDTH-1 with wrap=1.
  - Otherwise wrap=0.
- running is registered and high exactly while state==RUN.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. After deassertion the block is in IDLE and needs start.

Optional Feature:
Macro TERMINAL_STOP_EN.
- Defined:
  - Adds input limit [WIDTH-1:0] and output done (1 bit).
  - When a tick produces count==limit, the FSM goes to PAUSE on that same edge, and done<=1 and stays high.
  - done clears on start, clear or reset.
  - start while done=1 resumes counting past limit, with normal wrap.
- Undefined: ports absent; free-running wrap only.

Test Plan:
(DIV_VAL=3, so base P=4.)
1. Reset: hold rst_n=0 for 5 cycles -> count=0, running=0, tick=0, wrap=0. Pulse start, dir=1, rate_sel=0 -> running=1 next cycle; tick every 4 cycles; count 1,2,3 at cycles 4,8,12 after the start edge.
2. Up wrap: run up from 0 for 255 ticks to count=255. Next tick -> count=0 with wrap=1 for one cycle. Then dir=0 -> next tick count=255 with wrap=1.
3. Pause/resume: stop at count=5 -> running=0 and count holds 5 for 20 cycles with no tick. start -> tick with count=6 exactly 4 cycles later. Also, start and stop in the same cycle while in RUN -> PAUSE.
4. Rate change: rate_sel=2 -> tick period 16. Switch rate_sel to 0 when prescaler=10 -> tick on the next edge, then every 4 cycles.
5. Clear and reset: assert clear together with start while in RUN at count=9 -> count=0 and IDLE. Assert rst_n low mid-period, away from a clk edge -> outputs zero immediately.
6. TERMINAL_STOP_EN: limit=7, run up from 0 -> on the tick producing count=7, running=0 and done=1. start -> count=8 after 4 cycles, done=0.

Source files
------------

// File: rtl/count_rate_controller.sv
// rtl/count_rate_controller.sv - run/pause/clear sequencer with clock-enable prescaler and up/down count register
// Optional feature: define TERMINAL_STOP_EN to add the limit input and done output (pause when a tick lands on limit).
module count_rate_controller #(
    parameter int DIV_VAL = 4999,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             dir,
    input  logic [1:0]       rate_sel,
`ifdef TERMINAL_STOP_EN
    input  logic [WIDTH-1:0] limit,
    output logic             done,
`endif
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tick,
    output logic             wrap
);

    // Prescaler must reach (DIV_VAL+1)*8-1, the terminal value of the slowest rate.
    localparam int PW = $clog2((DIV_VAL + 1) * 8);
    localparam logic [PW:0] BASE_PERIOD = (PW + 1)'(DIV_VAL + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             running_q, running_d;

    logic [PW:0]      period_m1;
    logic             presc_at_end;
    logic             start_ok;
    logic             tick_now;
    logic             terminal_hit;
    logic [WIDTH-1:0] count_step;

`ifdef TERMINAL_STOP_EN
    logic             done_q, done_d;
`endif

    // Terminal prescaler value for the selected rate, the >= compare and the qualified start/tick events.
    always_comb begin
        period_m1    = (BASE_PERIOD << rate_sel) - (PW + 1)'(1);
        presc_at_end = ({1'b0, presc_q} >= period_m1);
        // Stop beats start in the same cycle; start is only meaningful outside RUN.
        start_ok     = (state_q != ST_RUN) && start && !stop && !clear;
        // Stop in RUN takes priority over a tick landing on the same edge.
        tick_now     = !clear && (state_q == ST_RUN) && !stop && presc_at_end;
        count_step   = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
`ifdef TERMINAL_STOP_EN
        terminal_hit = tick_now && (count_step == limit);
`else
        terminal_hit = 1'b0;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: clear, then stop/terminal, then start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop || terminal_hit) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (start_ok) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs and datapath next values: prescaler, count, tick/wrap pulses.
    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        tick_d    = tick_now;
        wrap_d    = 1'b0;
        running_d = (state_d == ST_RUN);
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    count_d = '0;
                end
                ST_RUN: begin
                    if (stop) begin
                        presc_d = presc_q;
                    end else if (tick_now) begin
                        presc_d = '0;
                        count_d = count_step;
                        wrap_d  = dir ? (&count_q) : (count_q == '0);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    // A resume restarts a full period.
                    if (start_ok) begin
                        presc_d = '0;
                    end
                end
                default: begin
                    presc_d = '0;
                    count_d = '0;
                end
            endcase
        end
    end

`ifdef TERMINAL_STOP_EN
    // done latches on the terminal tick and is released by an accepted start or clear.
    always_comb begin
        done_d = done_q;
        if (clear || start_ok) begin
            done_d = 1'b0;
        end else if (terminal_hit) begin
            done_d = 1'b1;
        end
    end

    // done register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`endif

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_count_rate_controller.sv
// tb/tb_count_rate_controller.sv - scoreboard bench for count_rate_controller with DIV_VAL=3 (base period 4)
module tb_count_rate_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       clear;
    logic       dir;
    logic [1:0] rate_sel;
    logic [7:0] count;
    logic       running;
    logic       tick;
    logic       wrap;
`ifdef TERMINAL_STOP_EN
    logic [7:0] limit;
    logic       done;
    logic       term_mode;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       wr;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    count_rate_controller #(
        .DIV_VAL(3),
        .WIDTH  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .dir     (dir),
        .rate_sel(rate_sel),
`ifdef TERMINAL_STOP_EN
        .limit   (limit),
        .done    (done),
`endif
        .count   (count),
        .running (running),
        .tick    (tick),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef TERMINAL_STOP_EN
    // Outside the terminal test keep limit half a range away so it is never hit.
    always @(negedge clk) if (!term_mode) limit = count + 8'd128;
`endif

    // Scoreboard: every tick must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_tick: tick at cycle %0d count=%0d, no tick expected", cyc, count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (cyc !== e.cyc)
                    $display("FAIL tick_cycle: tick at cycle %0d, expected cycle %0d", cyc, e.cyc);
                else n_pass++;
                n_checks++;
                if (count !== e.cnt)
                    $display("FAIL tick_count: count=%0d, expected %0d (cycle %0d)", count, e.cnt, cyc);
                else n_pass++;
                n_checks++;
                if (wrap !== e.wr)
                    $display("FAIL tick_wrap: wrap=%0b, expected %0b (cycle %0d)", wrap, e.wr, cyc);
                else n_pass++;
            end
        end
    end

    task automatic push_exp(input int c, input logic [7:0] v, input logic w);
        exp_t e;
        e.cyc = c;
        e.cnt = v;
        e.wr  = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s: %0d expected ticks still pending after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic pulse_start(output int e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = cyc;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (count !== 8'd0) $display("FAIL reset_count: count=%0d, expected 0", count); else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("FAIL reset_running: running=%0b, expected 0", running); else n_pass++;
        n_checks++;
        if (tick !== 1'b0) $display("FAIL reset_tick: tick=%0b, expected 0", tick); else n_pass++;
        n_checks++;
        if (wrap !== 1'b0) $display("FAIL reset_wrap: wrap=%0b, expected 0", wrap); else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (running !== 1'b0) $display("FAIL idle_after_reset: running=%0b, expected 0", running); else n_pass++;
    endtask

    task automatic test_count_and_wrap();
        int e;
        dir = 1'b1;
        rate_sel = 2'd0;
        pulse_start(e);
        n_checks++;
        if (running !== 1'b1) $display("FAIL start_running: running=%0b, expected 1", running); else n_pass++;
        for (int k = 1; k <= 256; k++) push_exp(e + 4 * k, 8'(k), (k == 256));
        wait_drain(1100, "up_run_drain");
        @(negedge clk);
        dir = 1'b0;
        push_exp(e + 4 * 257, 8'd255, 1'b1);
        push_exp(e + 4 * 258, 8'd254, 1'b0);
        wait_drain(20, "down_wrap_drain");
    endtask

    task automatic test_pause_resume();
        int  e;
        bit  bad;
        do_clear();
        dir = 1'b1;
        rate_sel = 2'd0;
        pulse_start(e);
        for (int k = 1; k <= 5; k++) push_exp(e + 4 * k, 8'(k), 1'b0);
        wait_drain(40, "pause_pre_drain");
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (running !== 1'b0) $display("FAIL stop_running: running=%0b, expected 0", running); else n_pass++;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (count !== 8'd5 || tick !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL pause_hold: count=%0d tick=%0b, expected count 5 and no tick for 20 cycles", count, tick);
        else n_pass++;
        pulse_start(e);
        n_checks++;
        if (running !== 1'b1) $display("FAIL resume_running: running=%0b, expected 1", running); else n_pass++;
        push_exp(e + 4, 8'd6, 1'b0);
        wait_drain(10, "resume_drain");
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (running !== 1'b0) $display("FAIL start_stop_same: running=%0b, expected 0", running); else n_pass++;
        repeat (8) @(negedge clk);
        n_checks++;
        if (count !== 8'd6) $display("FAIL start_stop_hold: count=%0d, expected 6", count); else n_pass++;
    endtask

    task automatic test_rate_change();
        int e;
        int i;
        do_clear();
        dir = 1'b1;
        rate_sel = 2'd2;
        pulse_start(e);
        push_exp(e + 16, 8'd1, 1'b0);
        push_exp(e + 27, 8'd2, 1'b0);
        push_exp(e + 31, 8'd3, 1'b0);
        push_exp(e + 35, 8'd4, 1'b0);
        // Prescaler restarts at 0 after the tick at e+16 and reads 10 after edge e+26.
        i = 0;
        while (cyc != e + 26 && i < 60) begin
            @(negedge clk);
            i++;
        end
        rate_sel = 2'd0;
        wait_drain(30, "rate_change_drain");
    endtask

    task automatic test_clear_reset();
        int e;
        do_clear();
        dir = 1'b1;
        rate_sel = 2'd0;
        pulse_start(e);
        for (int k = 1; k <= 9; k++) push_exp(e + 4 * k, 8'(k), 1'b0);
        wait_drain(60, "clear_pre_drain");
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        n_checks++;
        if (count !== 8'd0) $display("FAIL clear_count: count=%0d, expected 0", count); else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("FAIL clear_running: running=%0b, expected 0", running); else n_pass++;
        repeat (8) @(negedge clk);
        pulse_start(e);
        push_exp(e + 4, 8'd1, 1'b0);
        push_exp(e + 8, 8'd2, 1'b0);
        wait_drain(20, "async_pre_drain");
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 8'd0 || running !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0)
            $display("FAIL async_reset: count=%0d running=%0b tick=%0b wrap=%0b, expected all 0",
                     count, running, tick, wrap);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (count !== 8'd0 || running !== 1'b0)
            $display("FAIL post_reset_idle: count=%0d running=%0b, expected 0 and 0", count, running);
        else n_pass++;
    endtask

`ifdef TERMINAL_STOP_EN
    task automatic test_terminal_stop();
        int e;
        do_clear();
        term_mode = 1'b1;
        limit = 8'd7;
        dir = 1'b1;
        rate_sel = 2'd0;
        pulse_start(e);
        for (int k = 1; k <= 7; k++) push_exp(e + 4 * k, 8'(k), 1'b0);
        wait_drain(40, "terminal_drain");
        n_checks++;
        if (running !== 1'b0 || done !== 1'b1)
            $display("FAIL terminal_stop: running=%0b done=%0b, expected 0 and 1", running, done);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (count !== 8'd7 || done !== 1'b1)
            $display("FAIL terminal_hold: count=%0d done=%0b, expected 7 and 1", count, done);
        else n_pass++;
        pulse_start(e);
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_clear: done=%0b, expected 0", done); else n_pass++;
        push_exp(e + 4, 8'd8, 1'b0);
        wait_drain(10, "terminal_resume_drain");
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        dir      = 1'b1;
        rate_sel = 2'd0;
`ifdef TERMINAL_STOP_EN
        term_mode = 1'b0;
        limit     = 8'd128;
`endif
        test_reset();
        test_count_and_wrap();
        test_pause_resume();
        test_rate_change();
        test_clear_reset();
`ifdef TERMINAL_STOP_EN
        test_terminal_stop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
